// File: rtl/bcd_pkg.sv
// Shared types for the packed-BCD to binary converter.
// Optional digit checking: define BCD2BIN_ERRCHK_EN.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef logic [BCD_DIGIT_W-1:0] bcd_digit_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } bcd2bin_state_t;

endpackage

// File: rtl/bcd_mac10.sv
// One Horner step: acc_next = acc*10 + digit.
// Pure combinational, shift-add form of the multiply.
import bcd_pkg::*;

module bcd_mac10 #(
  parameter int ACC_W = 18
) (
  input  logic [ACC_W-1:0] i_acc,
  input  bcd_digit_t       i_digit,
  output logic [ACC_W-1:0] o_acc_next
);

  logic [ACC_W-1:0] w_x8;
  logic [ACC_W-1:0] w_x2;
  logic [ACC_W-1:0] w_dig;

  assign w_x8 = i_acc << 3;
  assign w_x2 = i_acc << 1;
  assign w_dig = {{(ACC_W-BCD_DIGIT_W){1'b0}}, i_digit};

  // acc*10 as (acc<<3)+(acc<<1), then add the digit
  always_comb begin
    o_acc_next = w_x8 + w_x2 + w_dig;
  end

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential packed-BCD to binary converter, MS digit first.
// Define BCD2BIN_ERRCHK_EN to flag digits above 9.
import bcd_pkg::*;

module bcd2bin_seq #(
  parameter int NDIGITS = 4,
  localparam int BIN_W = $clog2(10**NDIGITS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [BCD_DIGIT_W*NDIGITS-1:0] bcd_in,
  input  logic                           in_valid,
  output logic                           in_ready,
  output logic [BIN_W-1:0]               binary,
  output logic                           error,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int SH_W  = BCD_DIGIT_W * NDIGITS;
  localparam int ACC_W = BIN_W + 4;
  localparam int CNT_W = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NDIGITS - 1);

  bcd2bin_state_t r_state;
  bcd2bin_state_t w_state_nxt;

  logic [SH_W-1:0]  r_shreg;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             w_err;

  bcd_digit_t       w_top;
  logic [ACC_W-1:0] w_acc_nxt;
  logic             w_take;
  logic             w_last;

  assign w_top  = r_shreg[SH_W-1 -: BCD_DIGIT_W];
  assign w_take = (r_state == IDLE) && in_valid;
  assign w_last = (r_cnt == CNT_LAST);

  bcd_mac10 #(
    .ACC_W(ACC_W)
  ) u_mac (
    .i_acc     (r_acc),
    .i_digit   (w_top),
    .o_acc_next(w_acc_nxt)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // next state and handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_state_nxt = CONV;
      end
      CONV: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // capture, then consume one digit per cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_shreg <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (w_take) begin
      r_shreg <= bcd_in;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (r_state == CONV) begin
      r_shreg <= r_shreg << BCD_DIGIT_W;
      r_acc   <= w_acc_nxt;
      r_cnt   <= r_cnt + 1'b1;
    end
  end

`ifdef BCD2BIN_ERRCHK_EN
  logic r_err;

  // sticky per-conversion bad-digit flag
  always_ff @(posedge clk) begin
    if (rst)
      r_err <= 1'b0;
    else if (w_take)
      r_err <= 1'b0;
    else if (r_state == CONV && w_top > 4'd9)
      r_err <= 1'b1;
  end

  assign w_err = r_err;
`else
  assign w_err = 1'b0;
`endif

  // result is only presented while DONE; bad input forces zero
  always_comb begin
    binary = '0;
    error  = 1'b0;
    if (r_state == DONE) begin
      error = w_err;
      if (!w_err) binary = r_acc[BIN_W-1:0];
    end
  end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed plus random bench for bcd2bin_seq against a
// place-value reference model.
module tb_bcd2bin_seq;

  localparam int ND  = 4;
  localparam int BW  = 14;
  localparam int LAT = ND + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [15:0]   bcd_in = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [BW-1:0] binary;
  logic          error;
  logic          out_valid;
  logic          out_ready = 1'b0;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  bcd2bin_seq #(.NDIGITS(ND)) dut (
    .clk      (clk),
    .rst      (rst),
    .bcd_in   (bcd_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .binary   (binary),
    .error    (error),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // reference: sum of digit*10^position, error if any digit > 9
  function automatic void model(input logic [15:0] v,
                                output logic [BW-1:0] b,
                                output logic e);
    longint sum;
    longint pw;
    int d;
    sum = 0;
    pw  = 1;
    e   = 1'b0;
    for (int i = 0; i < ND; i++) begin
      d = int'((v >> (4 * i)) & 16'hF);
      if (d > 9) e = 1'b1;
      sum += longint'(d) * pw;
      pw  *= 10;
    end
    b = BW'(sum % (longint'(1) << BW));
`ifdef BCD2BIN_ERRCHK_EN
    if (e) b = '0;
`else
    e = 1'b0;
`endif
  endfunction

  // out_valid and in_ready must never coincide
  always @(negedge clk) begin
    if (!rst) check("excl", {31'd0, out_valid & in_ready}, 32'd0);
  end

  task automatic convert(input logic [15:0] v, input int hold,
                         input string tag);
    logic [BW-1:0] eb;
    logic ee;
    int cyc;
    model(v, eb, ee);
    check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    bcd_in   = v;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    bcd_in   = 16'($urandom);
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, cyc, LAT);
    check({tag, "_bin"}, {18'd0, binary}, {18'd0, eb});
    check({tag, "_err"}, {31'd0, error}, {31'd0, ee});
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      @(negedge clk);
      check({tag, "_hv"}, {31'd0, out_valid}, 32'd1);
      check({tag, "_hb"}, {18'd0, binary}, {18'd0, eb});
      check({tag, "_hr"}, {31'd0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_ov0"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_ir1"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [15:0] vals [4];
    logic [BW-1:0] eb;
    logic ee;
    logic seen;
    int got;
    int cyc;
    int idx;
    logic [15:0] v;

    repeat (2) @(negedge clk);
    check("rst_rdy", {31'd0, in_ready}, 32'd1);
    check("rst_ov", {31'd0, out_valid}, 32'd0);
    check("rst_bin", {18'd0, binary}, 32'd0);
    check("rst_err", {31'd0, error}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    convert(16'h0000, 0, "zero");
    convert(16'h9999, 0, "max");
    convert(16'h0042, 5, "hold");

    // reset mid-conversion discards it
    bcd_in   = 16'h1234;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
    end
    check("rstmid_ov", {31'd0, seen}, 32'd0);
    check("rstmid_rdy", {31'd0, in_ready}, 32'd1);

    convert(16'h5678, 0, "after_rst");
    convert(16'h12A4, 1, "badnib");

    // back-to-back with in_valid held high
    vals[0] = 16'h0001;
    vals[1] = 16'h0010;
    vals[2] = 16'h0100;
    vals[3] = 16'h1000;
    idx = 0;
    got = 0;
    cyc = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    bcd_in    = vals[0];
    while (got < 4 && cyc < 60) begin
      if (out_valid) begin
        model(vals[got], eb, ee);
        check("b2b_bin", {18'd0, binary}, {18'd0, eb});
        got++;
      end
      if (in_ready) begin
        if (idx < 4) begin
          bcd_in = vals[idx];
          idx++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("b2b_cnt", got, 4);
    repeat (2) @(negedge clk);

    // random values, mostly legal digits
    for (int r = 0; r < 24; r++) begin
      if (r % 4 == 3) begin
        v = 16'($urandom);
      end else begin
        v = '0;
        for (int d = 0; d < ND; d++)
          v = v | (16'($urandom_range(0, 9)) << (4 * d));
      end
      convert(v, int'($urandom_range(0, 3)), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
